// File: rtl/bmc_encoder.sv
// USB-PD biphase-mark (BMC) line encoder for the CC wire.
// Takes a ready/valid bit stream from the PHY TX path and drives the line
// level and driver enable. After the frame it appends the end-of-frame
// trailer and a hold-low period, then releases the line.
module bmc_encoder #(
  parameter int SYSTEM_KHZ  = 200000,
  parameter int BIT_KHZ     = 300,
  parameter int HOLD_LOW_NS = 1000
) (
  input  logic i_clock,
  input  logic i_nrst,
  input  logic i_enable,
  input  logic i_tx_valid,
  input  logic i_tx_data,
  input  logic i_tx_last,
  output logic o_tx_ready,
  output logic o_bmc_out,
  output logic o_bmc_oe,
  output logic o_busy,
  output logic o_underrun
);

  localparam int HALF = SYSTEM_KHZ / (2 * BIT_KHZ);
  localparam int UI   = 2 * HALF;
  localparam int HOLD = (SYSTEM_KHZ * HOLD_LOW_NS) / 1000000;
  localparam int CW   = $clog2(UI);
  localparam int HW   = $clog2(HOLD + 1);

  // Counter compare points. Outputs are registered, so every action is
  // decided one count early to become visible at the nominal count.
  localparam logic [CW-1:0] CNT_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(UI - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [HW-1:0] HOLD_END    = HW'(HOLD - 1);
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND     = 2'd1,
    S_TAIL     = 2'd2,
    S_HOLD_LOW = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hcnt;
  logic          r_bit;
  logic          r_last;
  logic          r_out;
  logic          r_oe;
  logic          r_underrun;
  logic          r_live;

  logic          w_ready;
  logic          w_accept;

  // Ready: IDLE follows enable; in SEND only on the final cycle of a bit
  // that is not the last one, so the next bit starts with no gap. r_live
  // keeps ready low while reset is asserted.
  always_comb begin
    w_ready = 1'b0;
    if (r_live && i_enable) begin
      case (r_state)
        S_IDLE:  w_ready = 1'b1;
        S_SEND:  w_ready = (r_cnt == CNT_LAST) && !r_last;
        default: w_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = i_tx_valid & w_ready;

  // Frame sequencer: bit timing, BMC toggling, trailer and hold-low.
  always_ff @(posedge i_clock or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hcnt     <= '0;
      r_bit      <= 1'b0;
      r_last     <= 1'b0;
      r_out      <= 1'b0;
      r_oe       <= 1'b0;
      r_underrun <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_live     <= 1'b1;
      r_underrun <= 1'b0;
      if (!i_enable) begin
        // Abort: drop the line and the driver, forget the held bit.
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_hcnt  <= '0;
        r_bit   <= 1'b0;
        r_last  <= 1'b0;
        r_out   <= 1'b0;
        r_oe    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_out <= 1'b0;
            r_oe  <= 1'b0;
            if (w_accept) begin
              r_state <= S_SEND;
              r_cnt   <= '0;
              r_bit   <= i_tx_data;
              r_last  <= i_tx_last;
              r_out   <= 1'b1;
              r_oe    <= 1'b1;
            end
          end
          S_SEND: begin
            if (r_cnt == CNT_LAST) begin
              r_cnt <= '0;
              if (w_accept) begin
                r_bit  <= i_tx_data;
                r_last <= i_tx_last;
                r_out  <= ~r_out;
              end else begin
                // Missing bit before tx_last is handled as the frame end.
                if (!r_last) r_underrun <= 1'b1;
                r_hcnt  <= '0;
                r_state <= r_out ? S_TAIL : S_HOLD_LOW;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
              if ((r_cnt == CNT_HALF_M1) && r_bit) r_out <= ~r_out;
            end
          end
          S_TAIL: begin
            // Line ended high: keep it high for half a UI, then pull low.
            if (r_cnt == CNT_HALF_M1) begin
              r_cnt   <= '0;
              r_hcnt  <= '0;
              r_out   <= 1'b0;
              r_state <= S_HOLD_LOW;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_HOLD_LOW: begin
            r_out <= 1'b0;
            if (r_hcnt == HOLD_END) begin
              r_hcnt  <= '0;
              r_oe    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_hcnt <= r_hcnt + HOLD_ONE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_tx_ready = w_ready;
  assign o_bmc_out  = r_out;
  assign o_bmc_oe   = r_oe;
  assign o_busy     = (r_state != S_IDLE);
  assign o_underrun = r_underrun;

endmodule
